game_round_timer: RTL

Downstream consumer of the divided game clock. Synchronises the slow `Tick_in` level into the `Clock` domain and edge-detects it into single-cycle tick pulses. Scales the ticks into seconds and runs the round state machine: idle, pre-start countdown, run, pause, game over. Outputs a BCD seconds display, a BCD hit score and round status to the display and scoring logic.

---
 rtl/game_pkg.sv | 40 ++++
 rtl/game_round_timer_if.sv | 17 +
 rtl/tick_edge_sync.sv | 30 +++
 rtl/game_round_timer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and BCD helpers for the round timer and the scoring display.
// Two-digit BCD values are packed {tens, units} in one byte.
package game_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_BYTE_W  = 2 * BCD_DIGIT_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    function automatic logic [BCD_BYTE_W-1:0] to_bcd(input int unsigned v);
        logic [BCD_DIGIT_W-1:0] hi, lo;
        hi = BCD_DIGIT_W'(v / 10);
        lo = BCD_DIGIT_W'(v % 10);
        return {hi, lo};
    endfunction

    // Saturates at 99 so a long run of hits never wraps the score.
    function automatic logic [BCD_BYTE_W-1:0] bcd_inc_sat(input logic [BCD_BYTE_W-1:0] b);
        logic [BCD_DIGIT_W-1:0] hi, lo;
        {hi, lo} = b;
        if (b == 8'h99)   return b;
        else if (lo == 4'd9) return {hi + 4'd1, 4'd0};
        else              return {hi, lo + 4'd1};
    endfunction

    function automatic logic [BCD_BYTE_W-1:0] bcd_dec(input logic [BCD_BYTE_W-1:0] b);
        logic [BCD_DIGIT_W-1:0] hi, lo;
        {hi, lo} = b;
        if (b == 8'h00)      return b;
        else if (lo == 4'd0) return {hi - 4'd1, 4'd9};
        else                 return {hi, lo - 4'd1};
    endfunction

endpackage

// File: rtl/game_round_timer_if.sv
// Button inputs and display/status outputs of the round timer.
// slave is the timer side, master the driver of buttons and consumer of outputs.
interface game_round_timer_if;
    logic       Start;
    logic       Pause;
    logic       Hit;
    logic       Tick_pulse;
    logic [2:0] State;
    logic [7:0] Seconds_bcd;
    logic [7:0] Score_bcd;
    logic       Time_up;

    modport slave  (input  Start, Pause, Hit,
                    output Tick_pulse, State, Seconds_bcd, Score_bcd, Time_up);
    modport master (output Start, Pause, Hit,
                    input  Tick_pulse, State, Seconds_bcd, Score_bcd, Time_up);
endinterface

// File: rtl/tick_edge_sync.sv
// Synchronises an asynchronous slow level and emits a registered one-cycle pulse per rising edge.
// Latency: SYNC_STAGES+1 clock edges from level rise to pulse.
module tick_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic i_level,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_pulse;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_level};
            r_prev  <= r_sync[SYNC_STAGES-1];
            r_pulse <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/game_round_timer.sv
// Round timer: tick prescaler to seconds, idle/countdown/run/pause/over FSM, BCD time and score.
// Button edges act two edges after the input rises; GAME_ROUND_TIMER_PAUSE_EN enables the PAUSE state.
module game_round_timer
    import game_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int TICKS_PER_SEC     = 5,
    parameter int GAME_SECONDS      = 60,
    parameter int COUNTDOWN_SECONDS = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Tick_in,
    game_round_timer_if.slave  bus
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]         PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [BCD_BYTE_W-1:0] GAME_BCD  = to_bcd(GAME_SECONDS);
    localparam logic [BCD_BYTE_W-1:0] CD_BCD    = to_bcd(COUNTDOWN_SECONDS);

    logic                  w_tick_pulse;
    logic                  r_start_q, r_start_edge;
    logic                  r_hit_q, r_hit_edge;
    logic [PW-1:0]         r_presc;
    state_e                r_state, w_state_nxt;
    logic [BCD_BYTE_W-1:0] r_seconds, w_seconds_nxt;
    logic [BCD_BYTE_W-1:0] r_score, w_score_nxt;
    logic                  r_time_up;
    logic                  w_presc_clr;
    logic                  w_counting;
    logic                  w_sec_strobe;
    logic                  w_final_strobe;

    tick_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_level (Tick_in),
        .o_pulse (w_tick_pulse)
    );

`ifdef GAME_ROUND_TIMER_PAUSE_EN
    logic r_pause_q, r_pause_edge;
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_pause_q    <= 1'b0;
            r_pause_edge <= 1'b0;
        end else begin
            r_pause_q    <= bus.Pause;
            r_pause_edge <= bus.Pause & ~r_pause_q;
        end
    end
`else
    logic w_unused_pause;
    assign w_unused_pause = bus.Pause;
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_start_q    <= 1'b0;
            r_start_edge <= 1'b0;
            r_hit_q      <= 1'b0;
            r_hit_edge   <= 1'b0;
        end else begin
            r_start_q    <= bus.Start;
            r_start_edge <= bus.Start & ~r_start_q;
            r_hit_q      <= bus.Hit;
            r_hit_edge   <= bus.Hit & ~r_hit_q;
        end
    end

    assign w_counting     = (r_state == ST_COUNT) || (r_state == ST_RUN);
    assign w_sec_strobe   = w_counting && w_tick_pulse && (r_presc == PRESC_MAX);
    assign w_final_strobe = w_sec_strobe && (r_seconds == 8'h01);

    // PAUSE<->RUN transitions keep the prescaler so a resumed second is not lengthened.
    always_ff @(posedge Clock) begin
        if (!Reset || w_presc_clr)
            r_presc <= '0;
        else if (w_counting && w_tick_pulse)
            r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state   <= ST_IDLE;
            r_seconds <= GAME_BCD;
            r_score   <= '0;
            r_time_up <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_seconds <= w_seconds_nxt;
            r_score   <= w_score_nxt;
            r_time_up <= (w_state_nxt == ST_OVER);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_seconds_nxt = r_seconds;
        w_score_nxt   = r_score;
        w_presc_clr   = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (r_start_edge) begin
                    w_state_nxt   = ST_COUNT;
                    w_seconds_nxt = CD_BCD;
                    w_score_nxt   = '0;
                    w_presc_clr   = 1'b1;
                end
            end
            ST_COUNT: begin
                if (w_final_strobe) begin
                    w_state_nxt   = ST_RUN;
                    w_seconds_nxt = GAME_BCD;
                    w_presc_clr   = 1'b1;
                end else if (w_sec_strobe) begin
                    w_seconds_nxt = bcd_dec(r_seconds);
                end
            end
            ST_RUN: begin
                if (r_hit_edge)
                    w_score_nxt = bcd_inc_sat(r_score);
                if (w_final_strobe) begin
                    w_state_nxt   = ST_OVER;
                    w_seconds_nxt = 8'h00;
                    w_presc_clr   = 1'b1;
                end else if (w_sec_strobe) begin
                    w_seconds_nxt = bcd_dec(r_seconds);
                end
`ifdef GAME_ROUND_TIMER_PAUSE_EN
                else if (r_pause_edge) begin
                    w_state_nxt = ST_PAUSE;
                end
`endif
            end
            ST_PAUSE: begin
`ifdef GAME_ROUND_TIMER_PAUSE_EN
                if (r_pause_edge)
                    w_state_nxt = ST_RUN;
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_presc_clr = 1'b1;
            end
        endcase
    end

    assign bus.Tick_pulse  = w_tick_pulse;
    assign bus.State       = r_state;
    assign bus.Seconds_bcd = r_seconds;
    assign bus.Score_bcd   = r_score;
    assign bus.Time_up     = r_time_up;

endmodule
